// File: rtl/udi_spect_issue.sv
// Burst issue controller for the UDI spectral datapath: streams I/Q samples into the
// external datapath and collects its delayed results in a first-word-fall-through FIFO.
module udi_spect_issue #(
    parameter int DP_LAT     = 3,
    parameter int DP_LAT_BYP = 2,
    parameter int DEPTH      = 4
) (
    input  logic        gclk,
    input  logic        greset_n,
    input  logic        start,
    input  logic [7:0]  cfg_count,
    input  logic [31:0] cfg_thr,
    input  logic [1:0]  cfg_mode,
    input  logic        cfg_res_sel,
    output logic        busy,
    output logic        done,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_i,
    input  logic [15:0] s_q,
    output logic [31:0] udi_rs,
    output logic [15:0] udi_rt,
    output logic        udi_ctl_thr_wr,
    output logic [1:0]  udi_ctl_sum_mode,
    output logic        udi_ctl_res_sel,
    input  logic [31:0] udi_rd,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [31:0] r_data,
    output logic        r_last
);

    localparam int LMAX = (DP_LAT > DP_LAT_BYP) ? DP_LAT : DP_LAT_BYP;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1) + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        THR   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      cnt_q;
    logic [31:0]     thr_q;
    logic [1:0]      mode_q;
    logic            res_sel_q;
    logic [7:0]      issued;
    logic [LMAX-1:0] vld_p;
    logic [LMAX-1:0] last_p;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   fifo_count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [31:0]     mem_data [DEPTH];
    logic            mem_last [DEPTH];

    logic            issue;
    logic            issue_last;
    logic            push;
    logic            pop;
    logic            tap_last;
    logic            fifo_empty;
    logic [CW:0]     occupancy;

    // Bits of the tag shift register that belong to the active latency.
    function automatic logic [LMAX-1:0] lat_mask(input logic [1:0] mode);
        logic [LMAX-1:0] m;
        int              l;
        l = (mode == 2'b11) ? DP_LAT_BYP : DP_LAT;
        for (int i = 0; i < LMAX; i++) begin
            m[i] = (i < l);
        end
        return m;
    endfunction

    function automatic logic tap_sel(input logic [LMAX-1:0] v, input logic [1:0] mode);
        if (mode == 2'b11) begin
            return v[DP_LAT_BYP-1];
        end
        return v[DP_LAT-1];
    endfunction

    assign fifo_empty = (fifo_count == '0);
    // Reserved slots: buffered results plus results still inside the datapath.
    assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight};
    assign push       = tap_sel(vld_p, mode_q);
    assign tap_last   = tap_sel(last_p, mode_q);
    assign pop        = r_valid && r_ready;
    assign issue      = s_valid && s_ready;
    assign issue_last = issue && (issued == (cnt_q - 8'd1));

    always_comb begin
        state_nxt        = state;
        busy             = (state != IDLE);
        done             = 1'b0;
        s_ready          = 1'b0;
        udi_rs           = '0;
        udi_rt           = '0;
        udi_ctl_thr_wr   = 1'b0;
        udi_ctl_sum_mode = '0;
        udi_ctl_res_sel  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = THR;
                end
            end
            THR: begin
                udi_ctl_thr_wr   = 1'b1;
                udi_rs           = thr_q;
                udi_ctl_sum_mode = mode_q;
                udi_ctl_res_sel  = res_sel_q;
                state_nxt        = (cnt_q == 8'd0) ? DRAIN : RUN;
            end
            RUN: begin
                udi_ctl_sum_mode = mode_q;
                udi_ctl_res_sel  = res_sel_q;
                s_ready          = (issued < cnt_q) && (occupancy < DEPTH_W);
                if (s_valid && s_ready) begin
                    udi_rs = {s_i, 16'h0000};
                    udi_rt = s_q;
                    if (issued == (cnt_q - 8'd1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                udi_ctl_sum_mode = mode_q;
                udi_ctl_res_sel  = res_sel_q;
                if (inflight == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign r_valid = !fifo_empty;
    assign r_data  = fifo_empty ? 32'd0 : mem_data[rd_ptr];
    assign r_last  = fifo_empty ? 1'b0 : mem_last[rd_ptr];

    always_ff @(posedge gclk or negedge greset_n) begin
        if (!greset_n) begin
            state      <= IDLE;
            cnt_q      <= '0;
            thr_q      <= '0;
            mode_q     <= '0;
            res_sel_q  <= 1'b0;
            issued     <= '0;
            vld_p      <= '0;
            last_p     <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                cnt_q     <= cfg_count;
                thr_q     <= cfg_thr;
                mode_q    <= cfg_mode;
                res_sel_q <= cfg_res_sel;
                issued    <= '0;
            end else if (issue) begin
                issued <= issued + 8'd1;
            end
            // Tag pipeline: issue enters at bit 0, result is captured at the latency tap.
            vld_p      <= ((vld_p << 1) | LMAX'(issue)) & lat_mask(mode_q);
            last_p     <= ((last_p << 1) | LMAX'(issue_last)) & lat_mask(mode_q);
            inflight   <= inflight + CW'(issue) - CW'(push);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Result storage
    always_ff @(posedge gclk) begin
        if (push) begin
            mem_data[wr_ptr] <= udi_rd;
            mem_last[wr_ptr] <= tap_last;
        end
    end

endmodule

// File: tb/tb_udi_spect_issue.sv
// Randomized and directed bench for udi_spect_issue with a delayed-datapath stub and a
// scoreboard that predicts every result from the samples handed to the design.
module tb_udi_spect_issue;

    localparam int DP_LAT     = 3;
    localparam int DP_LAT_BYP = 2;
    localparam int DEPTH      = 4;

    logic        gclk = 1'b0;
    logic        greset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_count = '0;
    logic [31:0] cfg_thr = '0;
    logic [1:0]  cfg_mode = '0;
    logic        cfg_res_sel = 1'b0;
    logic        busy;
    logic        done;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_i = '0;
    logic [15:0] s_q = '0;
    logic [31:0] udi_rs;
    logic [15:0] udi_rt;
    logic        udi_ctl_thr_wr;
    logic [1:0]  udi_ctl_sum_mode;
    logic        udi_ctl_res_sel;
    logic [31:0] udi_rd = '0;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic [31:0] r_data;
    logic        r_last;

    udi_spect_issue #(
        .DP_LAT    (DP_LAT),
        .DP_LAT_BYP(DP_LAT_BYP),
        .DEPTH     (DEPTH)
    ) dut (
        .gclk            (gclk),
        .greset_n        (greset_n),
        .start           (start),
        .cfg_count       (cfg_count),
        .cfg_thr         (cfg_thr),
        .cfg_mode        (cfg_mode),
        .cfg_res_sel     (cfg_res_sel),
        .busy            (busy),
        .done            (done),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_i             (s_i),
        .s_q             (s_q),
        .udi_rs          (udi_rs),
        .udi_rt          (udi_rt),
        .udi_ctl_thr_wr  (udi_ctl_thr_wr),
        .udi_ctl_sum_mode(udi_ctl_sum_mode),
        .udi_ctl_res_sel (udi_ctl_res_sel),
        .udi_rd          (udi_rd),
        .r_valid         (r_valid),
        .r_ready         (r_ready),
        .r_data          (r_data),
        .r_last          (r_last)
    );

    always #5 gclk = ~gclk;

    int cyc = 0;
    always @(posedge gclk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Power of a complex sample, optionally halved, optionally compared against thr.
    function automatic logic [31:0] spect_result(input logic [15:0] i, input logic [15:0] q,
                                                 input logic [1:0] mode, input logic res_sel,
                                                 input logic [31:0] thr);
        longint      si;
        longint      sq;
        longint      pwr;
        logic [31:0] v;
        si  = longint'($signed(i));
        sq  = longint'($signed(q));
        pwr = si * si + sq * sq;
        case (mode)
            2'b00:   v = 32'd0;
            2'b01:   v = pwr[31:0];
            default: v = 32'(pwr >>> 1);
        endcase
        if (res_sel) return (v > thr) ? 32'd1 : 32'd0;
        return v;
    endfunction

    // Datapath stub: result of the operands seen in a cycle appears on udi_rd L cycles later.
    logic [31:0] dp_pipe [8];
    logic [31:0] dp_thr = '0;
    initial begin
        foreach (dp_pipe[k]) dp_pipe[k] = '0;
        forever begin
            @(negedge gclk);
            if (!greset_n) begin
                foreach (dp_pipe[k]) dp_pipe[k] = '0;
                udi_rd = '0;
            end else begin
                if (udi_ctl_thr_wr) dp_thr = udi_rs;
                for (int k = 7; k > 0; k--) dp_pipe[k] = dp_pipe[k-1];
                dp_pipe[0] = udi_ctl_thr_wr ? 32'd0 :
                             spect_result(udi_rs[31:16], udi_rt, udi_ctl_sum_mode, udi_ctl_res_sel, dp_thr);
                udi_rd = dp_pipe[(udi_ctl_sum_mode == 2'b11) ? DP_LAT_BYP : DP_LAT];
            end
        end
    end

    // Sink pacing: 0 = hold low, 1 = hold high, 2 = random
    int rr_mode = 1;
    initial forever begin
        @(posedge gclk); #1;
        case (rr_mode)
            0:       r_ready = 1'b0;
            1:       r_ready = 1'b1;
            default: r_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic [32:0] exp_q [$];
    logic [31:0] got_q [$];
    logic        got_last [$];
    int          n_iss = 0;
    int          n_pop = 0;
    int          burst_iss = 0;
    int          done_cnt = 0;
    int          sready_seen = 0;
    int          rvalid_seen = 0;
    int          last_issue_cyc = 0;
    int          cur_count = 0;
    logic [1:0]  cur_mode = '0;
    logic        cur_res_sel = 1'b0;
    logic [31:0] cur_thr = '0;

    initial forever begin
        logic [32:0] e;
        @(negedge gclk);
        if (greset_n) begin
            if (s_ready) begin
                sready_seen++;
                check_eq("credit", 32'((n_iss - n_pop) < DEPTH), 32'd1);
            end
            if (r_valid) rvalid_seen++;
            if (s_valid && s_ready) begin
                exp_q.push_back({(burst_iss + 1 == cur_count),
                                 spect_result(s_i, s_q, cur_mode, cur_res_sel, cur_thr)});
                burst_iss++;
                n_iss++;
                last_issue_cyc = cyc;
            end
            if (r_valid && r_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_result", r_data, 32'hdead_beef);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("r_data", r_data, e[31:0]);
                    check_eq("r_last", 32'(r_last), 32'(e[32]));
                end
                got_q.push_back(r_data);
                got_last.push_back(r_last);
                n_pop++;
            end
            if (done) done_cnt++;
        end
    end

    logic [15:0] samp_i [256];
    logic [15:0] samp_q [256];
    bit          valid_rand = 1'b0;
    bit          feed_abort = 1'b0;
    bit          feed_fin = 1'b0;

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctl"}, 32'({busy, done, s_ready, r_valid, r_last, udi_ctl_thr_wr,
                                     udi_ctl_res_sel, udi_ctl_sum_mode}), 32'd0);
        check_eq({tag, "_rs"}, udi_rs, 32'd0);
        check_eq({tag, "_rt"}, 32'(udi_rt), 32'd0);
        check_eq({tag, "_rdata"}, r_data, 32'd0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        got_q.delete();
        got_last.delete();
        n_iss = 0;
        n_pop = 0;
        burst_iss = 0;
    endtask

    task automatic start_burst(input int cnt, input logic [31:0] thr, input logic [1:0] mode,
                               input logic rs);
        cur_count   = cnt;
        cur_thr     = thr;
        cur_mode    = mode;
        cur_res_sel = rs;
        burst_iss   = 0;
        done_cnt    = 0;
        sready_seen = 0;
        rvalid_seen = 0;
        got_q.delete();
        got_last.delete();
        @(posedge gclk); #1;
        start       = 1'b1;
        cfg_count   = 8'(cnt);
        cfg_thr     = thr;
        cfg_mode    = mode;
        cfg_res_sel = rs;
        @(posedge gclk); #1;
        start       = 1'b0;
    endtask

    task automatic feed(input int n);
        int k;
        int guard;
        k = 0;
        guard = 0;
        while (k < n && !feed_abort && guard < 5000) begin
            @(posedge gclk); #1;
            if (feed_abort) break;
            if (valid_rand && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_i = samp_i[k];
                s_q = samp_q[k];
            end
            @(negedge gclk);
            if (s_valid && s_ready) k++;
            guard++;
        end
        if (!feed_abort) check_eq("feed_count", 32'(k), 32'(n));
        @(posedge gclk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int guard;
        guard = 0;
        while ((done_cnt == 0 || exp_q.size() != 0) && guard < 3000) begin
            @(negedge gclk); #1;
            guard++;
        end
        check_eq({tag, "_end"}, 32'(guard < 3000), 32'd1);
    endtask

    task automatic measure_latency(input string tag, input int exp_lat);
        int guard;
        guard = 0;
        while (!r_valid && guard < 20) begin
            @(negedge gclk);
            guard++;
        end
        check_eq(tag, 32'(cyc - last_issue_cyc), 32'(exp_lat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int guard;

        // Power-up reset
        greset_n = 1'b0;
        repeat (3) @(negedge gclk);
        check_reset_outputs("por");
        @(posedge gclk); #1;
        greset_n = 1'b1;
        clear_model();

        // Basic sum burst with threshold write
        rr_mode = 1;
        valid_rand = 1'b0;
        samp_i[0] = 16'd3;  samp_q[0] = 16'd4;
        samp_i[1] = 16'd10; samp_q[1] = 16'd10;
        start_burst(2, 32'd100, 2'b01, 1'b0);
        @(negedge gclk);
        check_eq("thr_wr", 32'(udi_ctl_thr_wr), 32'd1);
        check_eq("thr_rs", udi_rs, 32'd100);
        check_eq("thr_mode", 32'(udi_ctl_sum_mode), 32'd1);
        check_eq("thr_busy", 32'(busy), 32'd1);
        feed(2);
        wait_end("sum");
        check_eq("sum_n", 32'(got_q.size()), 32'd2);
        check_eq("sum_r0", got_q[0], 32'd25);
        check_eq("sum_r1", got_q[1], 32'd200);
        check_eq("sum_last0", 32'(got_last[0]), 32'd0);
        check_eq("sum_last1", 32'(got_last[1]), 32'd1);
        @(negedge gclk);
        check_eq("sum_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("idle_ctl", 32'({busy, udi_ctl_thr_wr, udi_ctl_sum_mode, udi_ctl_res_sel}), 32'd0);

        // Same burst, compare result
        start_burst(2, 32'd100, 2'b01, 1'b1);
        feed(2);
        wait_end("cmp");
        check_eq("cmp_r0", got_q[0], 32'd0);
        check_eq("cmp_r1", got_q[1], 32'd1);

        // Sumshift and bypass extremes with capture latency
        samp_i[0] = 16'h8000; samp_q[0] = 16'h8000;
        start_burst(1, 32'd0, 2'b10, 1'b0);
        feed(1);
        measure_latency("lat_sumshift", DP_LAT + 1);
        wait_end("shift");
        check_eq("shift_r0", got_q[0], 32'h4000_0000);
        start_burst(1, 32'd0, 2'b11, 1'b0);
        feed(1);
        measure_latency("lat_bypass", DP_LAT_BYP + 1);
        wait_end("byp");
        check_eq("byp_r0", got_q[0], 32'h4000_0000);

        // Backpressure: sink stalled, only DEPTH issues fit
        for (int k = 0; k < 8; k++) begin
            samp_i[k] = 16'($urandom);
            samp_q[k] = 16'($urandom);
        end
        rr_mode = 0;
        start_burst(8, 32'h1234, 2'b01, 1'b0);
        feed_fin = 1'b0;
        fork
            begin
                feed(8);
                feed_fin = 1'b1;
            end
        join_none
        repeat (20) @(negedge gclk);
        #1;
        check_eq("bp_issues", 32'(burst_iss), 32'(DEPTH));
        check_eq("bp_sready", 32'(s_ready), 32'd0);
        rr_mode = 1;
        guard = 0;
        while (!feed_fin && guard < 200) begin
            @(negedge gclk);
            guard++;
        end
        check_eq("bp_feed_fin", 32'(feed_fin), 32'd1);
        wait_end("bp");
        check_eq("bp_n", 32'(got_q.size()), 32'd8);

        // Empty burst and start while busy
        start_burst(0, 32'd0, 2'b01, 1'b0);
        start = 1'b1;
        cfg_count = 8'd5;
        @(posedge gclk); #1;
        start = 1'b0;
        @(negedge gclk);
        check_eq("zero_done", 32'(done), 32'd1);
        @(negedge gclk);
        check_eq("zero_idle", 32'({busy, done}), 32'd0);
        repeat (8) @(negedge gclk);
        #1;
        check_eq("zero_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("zero_sready", 32'(sready_seen), 32'd0);
        check_eq("zero_rvalid", 32'(rvalid_seen), 32'd0);

        // Full-length burst
        for (int k = 0; k < 255; k++) begin
            samp_i[k] = 16'($urandom);
            samp_q[k] = 16'($urandom);
        end
        start_burst(255, 32'h0, 2'b10, 1'b0);
        feed(255);
        wait_end("long");
        check_eq("long_n", 32'(got_q.size()), 32'd255);
        check_eq("long_last", 32'(got_last[254]), 32'd1);

        // Randomized bursts
        rr_mode = 2;
        valid_rand = 1'b1;
        for (int b = 0; b < 10; b++) begin
            cnt = $urandom_range(1, 20);
            for (int k = 0; k < cnt; k++) begin
                samp_i[k] = 16'($urandom);
                samp_q[k] = 16'($urandom);
            end
            start_burst(cnt, $urandom >> 1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            feed(cnt);
            wait_end("rnd");
            check_eq("rnd_n", 32'(got_q.size()), 32'(cnt));
        end

        // Reset in the middle of a burst
        rr_mode = 1;
        valid_rand = 1'b0;
        for (int k = 0; k < 5; k++) begin
            samp_i[k] = 16'($urandom);
            samp_q[k] = 16'($urandom);
        end
        start_burst(5, 32'h10, 2'b01, 1'b0);
        feed_abort = 1'b0;
        feed_fin = 1'b0;
        fork
            begin
                feed(5);
                feed_fin = 1'b1;
            end
        join_none
        guard = 0;
        while (burst_iss < 3 && guard < 100) begin
            @(negedge gclk); #1;
            guard++;
        end
        check_eq("mid_reach3", 32'(burst_iss), 32'd3);
        greset_n = 1'b0;
        feed_abort = 1'b1;
        s_valid = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        clear_model();
        repeat (2) @(posedge gclk);
        #1;
        greset_n = 1'b1;
        guard = 0;
        while (!feed_fin && guard < 20) begin
            @(negedge gclk);
            guard++;
        end
        feed_abort = 1'b0;
        rvalid_seen = 0;
        repeat (10) @(negedge gclk);
        #1;
        check_eq("post_rst_rvalid", 32'(rvalid_seen), 32'd0);
        samp_i[0] = 16'd7; samp_q[0] = 16'hfffe;
        start_burst(1, 32'd0, 2'b01, 1'b0);
        feed(1);
        wait_end("post_rst");
        repeat (6) @(negedge gclk);
        check_eq("post_rst_n", 32'(got_q.size()), 32'd1);
        check_eq("post_rst_r0", got_q[0], 32'd53);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
